// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage. Holds the PC, the instruction memory, the
// IF/ID register and a byte-serial program loader.
// Optional feature macro: IF_FLUSH_ON_JUMP_EN (squash the slot after a jump).
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_stall, i_halt            hold PC and IF/ID
//   i_jump, i_jump_addr        PC redirect resolved in ID
//   i_load_en, i_load_data     loader byte stream (little-endian words)
//   i_load_clear               soft restart of PC, IF/ID and loader
//   o_pc4, o_instruction       IF/ID register
//   o_pc                       current PC
//   o_halt_fetched             sticky, HALT word latched into IF/ID
//   o_load_words               complete words written by the loader, saturating
module instruction_fetch #(
   parameter int unsigned NB_ADDR = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_stall,
   input  logic               i_halt,
   input  logic               i_jump,
   input  logic [31:0]        i_jump_addr,
   input  logic               i_load_en,
   input  logic [7:0]         i_load_data,
   input  logic               i_load_clear,
   output logic [31:0]        o_pc4,
   output logic [31:0]        o_instruction,
   output logic [31:0]        o_pc,
   output logic               o_halt_fetched,
   output logic [NB_ADDR:0]   o_load_words
);

   localparam int unsigned NB_DATA   = 32;
   localparam int unsigned DEPTH     = 2 ** NB_ADDR;
   localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [NB_ADDR:0]   LOAD_MAX  = {1'b1, {NB_ADDR{1'b0}}};

   logic [NB_DATA-1:0] imem [DEPTH];

   logic [1:0]          byte_cnt;
   logic [23:0]         byte_buf;
   logic [NB_ADDR-1:0]  wr_ptr;

   logic [NB_ADDR-1:0]  rd_addr_c;
   logic [NB_DATA-1:0]  word_c;
   logic [NB_DATA-1:0]  pc_plus4_c;
   logic                is_halt_c;
   logic                hold_c;
   logic                wr_en_c;
   logic [NB_DATA-1:0]  wr_word_c;

   // Asynchronous read path; PC byte offset and upper bits are ignored.
   always_comb begin
      rd_addr_c  = o_pc[NB_ADDR+1:2];
      word_c     = imem[rd_addr_c];
      pc_plus4_c = o_pc + 32'd4;
      is_halt_c  = (word_c == HALT_WORD);
      hold_c     = i_halt || o_halt_fetched || i_stall;
      wr_en_c    = i_load_en && !i_load_clear && (byte_cnt == 2'd3);
      wr_word_c  = {i_load_data, byte_buf};
   end

   // Loader: collect three bytes, commit the word with the fourth.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         byte_cnt     <= 2'd0;
         byte_buf     <= 24'd0;
         wr_ptr       <= '0;
         o_load_words <= '0;
      end else if (i_load_clear) begin
         byte_cnt     <= 2'd0;
         byte_buf     <= 24'd0;
         wr_ptr       <= '0;
         o_load_words <= '0;
      end else if (i_load_en) begin
         byte_cnt <= byte_cnt + 2'd1;
         if (byte_cnt != 2'd3) begin
            byte_buf[{byte_cnt, 3'b000} +: 8] <= i_load_data;
         end else begin
            wr_ptr <= wr_ptr + NB_ADDR'(1);
            if (o_load_words != LOAD_MAX) begin
               o_load_words <= o_load_words + (NB_ADDR+1)'(1);
            end
         end
      end
   end

   // Instruction memory write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_c) begin
         imem[wr_ptr] <= wr_word_c;
      end
   end

   // PC and IF/ID register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_pc           <= 32'd0;
         o_pc4          <= 32'd0;
         o_instruction  <= 32'd0;
         o_halt_fetched <= 1'b0;
      end else if (i_load_clear) begin
         o_pc           <= 32'd0;
         o_pc4          <= 32'd0;
         o_instruction  <= 32'd0;
         o_halt_fetched <= 1'b0;
      end else if (!hold_c) begin
`ifdef IF_FLUSH_ON_JUMP_EN
         if (i_jump) begin
            // Slot instruction squashed to a NOP, including a HALT word.
            o_instruction <= 32'd0;
            o_pc4         <= 32'd0;
            o_pc          <= i_jump_addr;
         end else begin
            o_instruction <= word_c;
            o_pc4         <= pc_plus4_c;
            if (is_halt_c) begin
               o_halt_fetched <= 1'b1;
            end else begin
               o_pc <= pc_plus4_c;
            end
         end
`else
         // Delay slot: the sequential word is latched even when jumping.
         o_instruction <= word_c;
         o_pc4         <= pc_plus4_c;
         if (is_halt_c) begin
            o_halt_fetched <= 1'b1;
         end
         if (i_jump) begin
            o_pc <= i_jump_addr;
         end else if (!is_halt_c) begin
            o_pc <= pc_plus4_c;
         end
`endif
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed sequence with an expectation queue.
module tb_instruction_fetch;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, halt = 1'b1, jump = 1'b0;
   logic [31:0] jump_addr = 32'd0;
   logic        load_en = 1'b0, load_clear = 1'b0;
   logic [7:0]  load_data = 8'd0;
   logic [31:0] pc4, instr, pc;
   logic        halt_fetched;
   logic [8:0]  load_words;

   logic        s_halt = 1'b1, s_load_en = 1'b0, s_load_clear = 1'b0;
   logic [7:0]  s_load_data = 8'd0;
   logic [31:0] s_pc4, s_instr, s_pc;
   logic        s_halt_fetched;
   logic [2:0]  s_load_words;

   always #5 clk = ~clk;

   instruction_fetch #(.NB_ADDR(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_halt(halt),
      .i_jump(jump), .i_jump_addr(jump_addr), .i_load_en(load_en),
      .i_load_data(load_data), .i_load_clear(load_clear),
      .o_pc4(pc4), .o_instruction(instr), .o_pc(pc),
      .o_halt_fetched(halt_fetched), .o_load_words(load_words)
   );

   instruction_fetch #(.NB_ADDR(2)) dut_small (
      .i_clk(clk), .i_reset(reset), .i_stall(1'b0), .i_halt(s_halt),
      .i_jump(1'b0), .i_jump_addr(32'd0), .i_load_en(s_load_en),
      .i_load_data(s_load_data), .i_load_clear(s_load_clear),
      .o_pc4(s_pc4), .o_instruction(s_instr), .o_pc(s_pc),
      .o_halt_fetched(s_halt_fetched), .o_load_words(s_load_words)
   );

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic cmp(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] v);
      push(tag, v);
      cmp(obs);
   endtask

   // One edge of the main DUT with expected IF/ID and PC queued beforehand.
   task automatic fetch_step(input logic [31:0] ei, input logic [31:0] ep4, input logic [31:0] epc);
      push("instr", ei);
      push("pc4", ep4);
      push("pc", epc);
      @(posedge clk); #1;
      cmp(instr);
      cmp(pc4);
      cmp(pc);
   endtask

   task automatic load_byte(input logic [7:0] b);
      load_en = 1'b1;
      load_data = b;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) load_byte(w[8*k +: 8]);
   endtask

   task automatic s_load_byte(input logic [7:0] b);
      s_load_en = 1'b1;
      s_load_data = b;
      @(posedge clk); #1;
      s_load_en = 1'b0;
   endtask

   task automatic s_load_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) s_load_byte(w[8*k +: 8]);
   endtask

   task automatic s_step(input logic [31:0] ei, input logic [31:0] ep4);
      push("s_instr", ei);
      push("s_pc4", ep4);
      @(posedge clk); #1;
      cmp(s_instr);
      cmp(s_pc4);
   endtask

   logic [31:0] prog_a [4];
   logic [31:0] slot_i, slot_p4;

   initial begin
      prog_a[0] = 32'h2001_0005;
      prog_a[1] = 32'h2002_0007;
      prog_a[2] = 32'h0022_1820;
      prog_a[3] = 32'hFFFF_FFFF;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc, 32'd0);
      check("rst_pc4", pc4, 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_halt_fetched", 32'(halt_fetched), 32'd0);
      check("rst_load_words", 32'(load_words), 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // Load program A while halted
      for (int i = 0; i < 3; i++) load_word(prog_a[i]);
      check("load_words_3", 32'(load_words), 32'd3);
      load_word(prog_a[3]);
      check("load_words_4", 32'(load_words), 32'd4);
      check("halted_pc", pc, 32'd0);
      check("halted_instr", instr, 32'd0);

      // Sequential fetch, then stall at PC=8 (second stall cycle also jumps)
      halt = 1'b0;
      fetch_step(prog_a[0], 32'd4, 32'd4);
      fetch_step(prog_a[1], 32'd8, 32'd8);
      stall = 1'b1;
      fetch_step(prog_a[1], 32'd8, 32'd8);
      jump = 1'b1;
      jump_addr = 32'h40;
      fetch_step(prog_a[1], 32'd8, 32'd8);
      stall = 1'b0;
      jump = 1'b0;
      fetch_step(prog_a[2], 32'd12, 32'd12);

      // HALT word at word 3 freezes the stage
      fetch_step(32'hFFFF_FFFF, 32'd16, 32'd12);
      check("halt_fetched_set", 32'(halt_fetched), 32'd1);
      for (int i = 0; i < 10; i++) fetch_step(32'hFFFF_FFFF, 32'd16, 32'd12);
      check("halt_fetched_held", 32'(halt_fetched), 32'd1);

      // Soft restart
      load_clear = 1'b1;
      halt = 1'b1;
      fetch_step(32'd0, 32'd0, 32'd0);
      load_clear = 1'b0;
      check("clear_halt_fetched", 32'(halt_fetched), 32'd0);
      check("clear_load_words", 32'(load_words), 32'd0);

      // Program B: 17 words, then jump at PC=0x10
      for (int i = 0; i < 17; i++) load_word(32'h1000_0000 + 32'(i));
      check("load_words_17", 32'(load_words), 32'd17);
      halt = 1'b0;
      for (int i = 0; i < 4; i++)
         fetch_step(32'h1000_0000 + 32'(i), 32'(4 * (i + 1)), 32'(4 * (i + 1)));
      jump = 1'b1;
      jump_addr = 32'h40;
`ifdef IF_FLUSH_ON_JUMP_EN
      slot_i  = 32'd0;
      slot_p4 = 32'd0;
`else
      slot_i  = 32'h1000_0004;
      slot_p4 = 32'h14;
`endif
      fetch_step(slot_i, slot_p4, 32'h40);
      jump = 1'b0;
      fetch_step(32'h1000_0010, 32'h44, 32'h44);

      // Async reset with a partial loader word pending and no clock edge
      halt = 1'b1;
      load_byte(8'h11);
      load_en = 1'b1;
      load_data = 8'h22;
      #2;
      reset = 1'b0;
      #1;
      check("areset_pc", pc, 32'd0);
      check("areset_pc4", pc4, 32'd0);
      check("areset_instr", instr, 32'd0);
      check("areset_halt_fetched", 32'(halt_fetched), 32'd0);
      check("areset_load_words", 32'(load_words), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      load_en = 1'b0;
      halt = 1'b0;
      fetch_step(32'h1000_0000, 32'd4, 32'd4);

      // Partial word discarded: a fresh word lands intact at word 0
      halt = 1'b1;
      load_word(32'hDEAD_BEEF);
      check("reload_words", 32'(load_words), 32'd1);
      load_clear = 1'b1;
      fetch_step(32'd0, 32'd0, 32'd0);
      load_clear = 1'b0;
      halt = 1'b0;
      fetch_step(32'hDEAD_BEEF, 32'd4, 32'd4);
      fetch_step(32'h1000_0001, 32'd8, 32'd8);
      halt = 1'b1;

      // Small memory: pointer wrap, saturation, partial word dropped on clear
      for (int i = 0; i < 4; i++) s_load_word(32'h0A0A_0A00 + 32'(i));
      check("s_load_words_4", 32'(s_load_words), 32'd4);
      s_load_word(32'h0A0A_0A04);
      check("s_load_words_sat", 32'(s_load_words), 32'd4);
      s_load_byte(8'h55);
      s_load_byte(8'h66);
      s_load_byte(8'h77);
      s_load_clear = 1'b1;
      @(posedge clk); #1;
      s_load_clear = 1'b0;
      check("s_clear_words", 32'(s_load_words), 32'd0);
      s_halt = 1'b0;
      s_step(32'h0A0A_0A04, 32'd4);
      s_step(32'h0A0A_0A01, 32'd8);
      s_halt = 1'b1;

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Pipeline stage 1 (IF) of the MIPS core: holds the program counter, the instruction memory and the IF/ID pipeline register, and feeds `instruction_decode` directly with `o_pc4` and `o_instruction`. It also does the following:
- Redirects the PC on jumps and branches resolved in ID.
- Obeys stall from the hazard detector and halt from the debug unit.
- Freezes itself after fetching the HALT word (32'hFFFFFFFF).
- Contains a byte-serial program loader driven by the debug unit.

## Interface
Parameters:
- NB_ADDR, 8, instruction memory word-address width; depth 2^NB_ADDR words.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, asynchronous and active-low.
- i_stall  in  1  hazard detector: hold PC and IF/ID.
- i_halt  in  1  debug unit or ID halt: freeze PC and IF/ID.
- i_jump  in  1  ID jump/branch taken (combinational from ID).
- i_jump_addr  in  32  target byte address from ID.
- i_load_en  in  1  one program byte valid this cycle.
- i_load_data  in  8  program byte.
- i_load_clear  in  1  soft restart; loader pointer, PC and IF/ID to zero.
- o_pc4  out  32  IF/ID: address of latched instruction + 4.
- o_instruction  out  32  IF/ID: latched instruction.
- o_pc  out  32  current PC, for the debug unit.
- o_halt_fetched  out  1  sticky; the HALT word has been latched into IF/ID.
- o_load_words  out  NB_ADDR+1  count of complete words written by the loader, saturating.

## Operation
- Reset values (async, i_reset=0):
  - PC, o_pc4 and o_instruction are 0.
  - o_halt_fetched is 0.
  - The loader byte counter, word pointer and o_load_words are 0.
  - Memory contents are not reset.
- Memory read is asynchronous: word = imem[PC[NB_ADDR+1:2]]. PC[1:0] is ignored, and PC bits above NB_ADDR+1 are ignored (address aliasing).
- PC/IF-ID update priority, evaluated each edge:
  1. **i_load_clear:** PC, o_pc4, o_instruction and o_halt_fetched go to 0; the loader is cleared.
  2. **i_halt or o_halt_fetched:** PC and IF/ID hold.
  3. **i_stall:** PC and IF/ID hold; i_jump is ignored because the branch operands are invalid during a stall.
  4. **Otherwise:**
     - o_instruction <= word and o_pc4 <= PC+4.
     - PC <= i_jump ? i_jump_addr : PC+4.
     - If word == 32'hFFFFFFFF, o_halt_fetched <= 1 and PC holds, unless i_jump is set, in which case PC takes i_jump_addr.
- PC arithmetic is 32-bit modulo 2^32 with no checks.
- Loader:
  - Bytes are assembled little-endian: the first byte goes to bits [7:0], the fourth to bits [31:24].
  - The 2-bit byte counter advances on each i_load_en.
  - On the fourth byte, the word is written to imem[pointer], the pointer increments and o_load_words increments.
  - The pointer wraps at 2^NB_ADDR. o_load_words saturates at 2^NB_ADDR.
  - Loading is accepted in any state. A write to the currently addressed word is visible on the read path the next cycle.
  - i_load_clear together with i_load_en: clear wins and the byte is dropped.
  - A partial word (fewer than 4 bytes) is discarded on clear.

## Timing
- Fetch latency is 1 cycle: the word at PC appears on o_instruction after the next edge.
- A jump asserted in ID updates PC at the same edge that latches the sequential instruction. The target is fetched into IF/ID one edge later.
- Stall and halt are level-sensitive and take effect at the edge they are sampled. Release resumes on the next edge with no lost instruction.
- Async reset mid-operation discards any partial loader word. Reset deassertion is synchronous to the first following edge.

## Configuration
- IF_FLUSH_ON_JUMP_EN defined: on an unstalled, unhalted edge with i_jump=1, o_instruction <= 32'h00000000 (NOP) and o_pc4 <= 0. The sequential instruction is squashed; a HALT word in that slot is also squashed and does not set o_halt_fetched.
- Not defined: MIPS branch-delay-slot semantics; the sequential instruction is latched and executes.

## Test plan
- **Sequential fetch:**
  - Stimulus: load 12 bytes forming words 0x20010005, 0x20020007, 0x00221820; release reset.
  - Required: o_instruction shows them on cycles 1, 2, 3; o_pc4 = 4, 8, 12; o_load_words = 3.
- **Stall:**
  - Stimulus: assert i_stall for 2 cycles at PC=8.
  - Required: PC stays 8 and o_instruction holds 0x20020007; resume fetches 0x00221820 with no loss.
- **Jump:**
  - Stimulus: i_jump=1, i_jump_addr=0x40 at PC=0x10.
  - Required: next o_pc = 0x40. The slot instruction is imem[4] without the macro, or 0 with IF_FLUSH_ON_JUMP_EN. The following edge latches imem[16].
  - Also: i_jump together with i_stall leaves PC unchanged.
- **HALT:**
  - Stimulus: place 0xFFFFFFFF at word 3.
  - Required: o_halt_fetched = 1 with o_instruction = 0xFFFFFFFF and o_pc = 12, held for 10 cycles. i_load_clear returns PC to 0 and clears the flag.
- **Loader boundaries:**
  - Stimulus 1: NB_ADDR=2, load 5 words.
  - Required: the fifth word overwrites word 0 and o_load_words saturates at 4.
  - Stimulus 2: load 3 bytes, then i_load_clear.
  - Required: no write occurs.
- **Async reset:**
  - Stimulus: assert i_reset mid-load and mid-run, with no clock edge.
  - Required: all outputs go to 0 immediately; memory contents are retained.
